// File: rtl/pn_pkg.sv
// Shared definitions for the Polish-Notation token interface: mode/error codes,
// token field layout, FSM encoding and command validity helpers.
package pn_pkg;

   localparam int MAX_TOK = 12;
   localparam int TOK_W   = 4;
   localparam int OP_BIT  = 3;
   localparam int VAL_MSB = 2;

   typedef enum logic [1:0] {
      MODE_PRE_SORT   = 2'd0,
      MODE_POST_SORT  = 2'd1,
      MODE_PRE_STACK  = 2'd2,
      MODE_POST_STACK = 2'd3
   } pn_mode_e;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_BEATS   = 2'd3
   } pn_err_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_GAP  = 2'd3
   } pn_state_e;

   // Sorted modes take whole operator triples; stack modes need an odd token count.
   function automatic logic len_ok(input logic [1:0] mode, input logic [3:0] len,
                                   input logic [3:0] max_len);
      logic ok;
      if (len == 4'd0 || len > max_len) begin
         ok = 1'b0;
      end else if (mode[1] == 1'b0) begin
         ok = ((len % 4'd3) == 4'd0);
      end else begin
         ok = len[0];
      end
      return ok;
   endfunction

   function automatic logic [3:0] exp_beats(input logic [1:0] mode, input logic [3:0] len);
      return mode[1] ? 4'd1 : (len / 4'd3);
   endfunction

endpackage

// File: rtl/pn_token_tx_if.sv
// Command, token-bus, result and response signals of the PN transmitter.
interface pn_token_tx_if #(parameter int NTOK = pn_pkg::MAX_TOK);
   import pn_pkg::*;

   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [1:0]             cmd_mode;
   logic [3:0]             cmd_len;
   logic [TOK_W*NTOK-1:0]  cmd_tokens;
   logic [1:0]             mode;
   logic                   operator;
   logic [2:0]             in;
   logic                   in_valid;
   logic                   pn_out_valid;
   logic [31:0]            pn_out;
   logic                   rsp_valid;
   logic [31:0]            rsp_data;
   logic                   rsp_last;
   logic                   done;
   logic [1:0]             err;

   modport master (
      input  cmd_valid, cmd_mode, cmd_len, cmd_tokens, pn_out_valid, pn_out,
      output cmd_ready, mode, operator, in, in_valid, rsp_valid, rsp_data, rsp_last, done, err
   );

   modport slave (
      output cmd_valid, cmd_mode, cmd_len, cmd_tokens, pn_out_valid, pn_out,
      input  cmd_ready, mode, operator, in, in_valid, rsp_valid, rsp_data, rsp_last, done, err
   );

endinterface

// File: rtl/pn_tok_shift.sv
// Token register: token 0 passes straight through on load, the rest shift out one per beat.
module pn_tok_shift
   import pn_pkg::*;
#(
   parameter int NTOK = MAX_TOK
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  shift,
   input  logic [TOK_W*NTOK-1:0] data,
   output logic [TOK_W-1:0]      tok
);

   logic [TOK_W*NTOK-1:0] sr;

   // Holds tokens 1..n after a load so the head is always the next token to send.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else if (load) begin
         sr <= {{TOK_W{1'b0}}, data[TOK_W*NTOK-1:TOK_W]};
      end else if (shift) begin
         sr <= {{TOK_W{1'b0}}, sr[TOK_W*NTOK-1:TOK_W]};
      end
   end

   assign tok = load ? data[TOK_W-1:0] : sr[TOK_W-1:0];

endmodule

// File: rtl/pn_token_tx.sv
// PN token transmitter: serializes one command as a token burst, then forwards and
// checks the evaluator's result burst.
module pn_token_tx #(
   parameter int MAX_TOK     = 12,
   parameter int TIMEOUT_CYC = 64,
   parameter int GAP_CYC     = 2
) (
   input logic           clk,
   input logic           rst,
   pn_token_tx_if.master bus
);
   import pn_pkg::*;

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int GW = $clog2(GAP_CYC + 1);

   pn_state_e        state;
   logic [3:0]       len_r;
   logic [3:0]       idx;
   logic [3:0]       beats;
   logic [3:0]       beats_nxt;
   logic [3:0]       exp_r;
   logic             seen;
   logic [TW-1:0]    tmo_cnt;
   logic [GW-1:0]    gap_cnt;
   logic             accept;
   logic             cmd_ok;
   logic             load;
   logic             shift;
   logic [TOK_W-1:0] tok;

   assign accept    = bus.cmd_valid & bus.cmd_ready;
   assign cmd_ok    = len_ok(bus.cmd_mode, bus.cmd_len, 4'(MAX_TOK));
   assign load      = accept & cmd_ok & (state == ST_IDLE);
   assign shift     = (state == ST_SEND);
   assign beats_nxt = (beats == 4'd15) ? beats : beats + 4'd1;

   pn_tok_shift #(.NTOK(MAX_TOK)) u_shift (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift),
      .data  (bus.cmd_tokens),
      .tok   (tok)
   );

   // Transaction FSM with all bus outputs registered; done/err/rsp are single-cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         bus.cmd_ready <= 1'b1;
         bus.mode      <= 2'd0;
         bus.operator  <= 1'b0;
         bus.in        <= 3'd0;
         bus.in_valid  <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= 32'd0;
         bus.rsp_last  <= 1'b0;
         bus.done      <= 1'b0;
         bus.err       <= ERR_OK;
         len_r         <= 4'd0;
         idx           <= 4'd0;
         beats         <= 4'd0;
         exp_r         <= 4'd0;
         seen          <= 1'b0;
         tmo_cnt       <= '0;
         gap_cnt       <= '0;
      end else begin
         bus.done      <= 1'b0;
         bus.err       <= ERR_OK;
         bus.rsp_valid <= 1'b0;
         bus.rsp_last  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  bus.cmd_ready <= 1'b0;
                  len_r         <= bus.cmd_len;
                  exp_r         <= exp_beats(bus.cmd_mode, bus.cmd_len);
                  if (cmd_ok) begin
                     state        <= ST_SEND;
                     bus.in_valid <= 1'b1;
                     bus.mode     <= bus.cmd_mode;
                     bus.operator <= tok[OP_BIT];
                     bus.in       <= tok[VAL_MSB:0];
                     idx          <= 4'd1;
                  end else begin
                     state    <= ST_GAP;
                     gap_cnt  <= '0;
                     bus.done <= 1'b1;
                     bus.err  <= ERR_LEN;
                  end
               end
            end
            ST_SEND: begin
               bus.mode <= 2'd0;
               if (idx == len_r) begin
                  state        <= ST_WAIT;
                  bus.in_valid <= 1'b0;
                  bus.operator <= 1'b0;
                  bus.in       <= 3'd0;
                  beats        <= 4'd0;
                  seen         <= 1'b0;
                  tmo_cnt      <= '0;
               end else begin
                  bus.operator <= tok[OP_BIT];
                  bus.in       <= tok[VAL_MSB:0];
                  idx          <= idx + 4'd1;
               end
            end
            ST_WAIT: begin
               if (bus.pn_out_valid) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_data  <= bus.pn_out;
                  bus.rsp_last  <= (beats_nxt == exp_r);
                  beats         <= beats_nxt;
                  seen          <= 1'b1;
               end else if (seen) begin
                  // First idle cycle after at least one beat closes the burst.
                  state    <= ST_GAP;
                  gap_cnt  <= '0;
                  bus.done <= 1'b1;
                  bus.err  <= (beats == exp_r) ? ERR_OK : ERR_BEATS;
               end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                  state    <= ST_GAP;
                  gap_cnt  <= '0;
                  bus.done <= 1'b1;
                  bus.err  <= ERR_TIMEOUT;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            ST_GAP: begin
               if (gap_cnt == GW'(GAP_CYC - 1)) begin
                  state         <= ST_IDLE;
                  bus.cmd_ready <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: begin
               state         <= ST_IDLE;
               bus.cmd_ready <= 1'b1;
               bus.in_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pn_token_tx.sv
// Scoreboard bench for pn_token_tx: stimulus pushes expected tokens, result beats and
// done/err events; a negedge monitor pops and compares whenever the DUT presents them.
module tb_pn_token_tx;
   import pn_pkg::*;

   localparam int TMO = 64;
   localparam logic [1:0] REJ_MODE [5] = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd2};
   localparam logic [3:0] REJ_LEN  [5] = '{4'd4, 4'd0, 4'd13, 4'd15, 4'd4};

   typedef struct packed {logic [1:0] mode; logic op; logic [2:0] val;} tok_t;
   typedef struct packed {logic [31:0] data; logic last;} rsp_t;
   typedef struct packed {logic [1:0] err; logic timed; logic [31:0] cyc;} done_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   passed = 0;
   int   cyc = 0;
   tok_t  tok_q[$];
   rsp_t  rsp_q[$];
   done_t done_q[$];
   tok_t  mt;
   rsp_t  mr;
   done_t md;

   always #5 clk = ~clk;

   pn_token_tx_if #(.NTOK(12)) bus ();

   pn_token_tx #(.MAX_TOK(12), .TIMEOUT_CYC(TMO), .GAP_CYC(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic fail(input string name, input string msg);
      checks++;
      $display("FAIL %s: %s", name, msg);
   endtask

   // Monitor: compare every presented token beat, response beat and done event.
   always @(negedge clk) begin
      if (bus.in_valid) begin
         if (tok_q.size() == 0) begin
            fail("tok_unexpected", $sformatf("token op=%0d in=%0d, expected none", bus.operator, bus.in));
         end else begin
            mt = tok_q.pop_front();
            check("tok_mode", 32'(bus.mode), 32'(mt.mode));
            check("tok_operator", 32'(bus.operator), 32'(mt.op));
            check("tok_in", 32'(bus.in), 32'(mt.val));
         end
      end
      if (bus.rsp_valid) begin
         if (rsp_q.size() == 0) begin
            fail("rsp_unexpected", $sformatf("rsp_data=0x%0h, expected none", bus.rsp_data));
         end else begin
            mr = rsp_q.pop_front();
            check("rsp_data", bus.rsp_data, mr.data);
            check("rsp_last", 32'(bus.rsp_last), 32'(mr.last));
         end
      end
      if (bus.done) begin
         if (done_q.size() == 0) begin
            fail("done_unexpected", $sformatf("done with err=%0d, expected none", bus.err));
         end else begin
            md = done_q.pop_front();
            check("done_err", 32'(bus.err), 32'(md.err));
            if (md.timed) check("done_cycle", 32'(cyc), md.cyc);
         end
      end
   end

   task automatic issue(input logic [1:0] m, input logic [3:0] len, input logic [47:0] toks,
                        input bit reject, input int npush, output int acc);
      bit got;
      if (!reject) begin
         for (int k = 0; k < npush; k++)
            tok_q.push_back({(k == 0) ? m : 2'd0, toks[4*k+3], toks[4*k +: 3]});
      end
      @(posedge clk); #1;
      bus.cmd_valid  = 1'b1;
      bus.cmd_mode   = m;
      bus.cmd_len    = len;
      bus.cmd_tokens = toks;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) got = 1'b1;
      end
      if (!got) fail("cmd_ready_timeout", "cmd_ready never asserted within 100 cycles");
      @(posedge clk); #1;
      acc = cyc;
      bus.cmd_valid = 1'b0;
      if (reject && got) done_q.push_back({2'd1, 1'b1, 32'(acc)});
   endtask

   task automatic wait_burst_end(output int w);
      bit seen_tok;
      seen_tok = 1'b0;
      w = -1;
      for (int i = 0; i < 100 && w < 0; i++) begin
         @(negedge clk);
         if (bus.in_valid) seen_tok = 1'b1;
         else if (seen_tok) w = cyc;
      end
      if (w < 0) fail("burst_end_timeout", "token burst did not complete within 100 cycles");
   endtask

   task automatic send_beats(input logic [31:0] d[$], input int expn);
      for (int i = 0; i < d.size(); i++) begin
         @(posedge clk); #1;
         bus.pn_out_valid = 1'b1;
         bus.pn_out       = d[i];
         rsp_q.push_back({d[i], (i + 1) == expn});
      end
      @(posedge clk); #1;
      bus.pn_out_valid = 1'b0;
      bus.pn_out       = 32'd0;
   endtask

   task automatic wait_idle();
      bit empty;
      empty = 1'b0;
      for (int i = 0; i < 300 && !empty; i++) begin
         @(negedge clk);
         if (done_q.size() == 0 && rsp_q.size() == 0) empty = 1'b1;
      end
      if (!empty) fail("drain_timeout", "expected done/response events still pending after 300 cycles");
   endtask

   initial begin
      int a;
      int w;
      logic [31:0] bq[$];
      bus.cmd_valid    = 1'b0;
      bus.cmd_mode     = 2'd0;
      bus.cmd_len      = 4'd0;
      bus.cmd_tokens   = 48'd0;
      bus.pn_out_valid = 1'b0;
      bus.pn_out       = 32'd0;

      #12;
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_in_valid", 32'(bus.in_valid), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_mode", 32'(bus.mode), 32'd0);
      @(negedge clk); rst = 1'b0;

      // Result beats while idle must not be forwarded.
      @(posedge clk); #1; bus.pn_out_valid = 1'b1; bus.pn_out = 32'd99;
      @(posedge clk); @(posedge clk); #1; bus.pn_out_valid = 1'b0; bus.pn_out = 32'd0;

      // 1: mode3, tokens (0,3),(0,4),(1,0), result 7
      issue(2'd3, 4'd3, 48'h843, 1'b0, 3, a);
      wait_burst_end(w);
      check("t1_burst_len", 32'(w), 32'(a + 3));
      done_q.push_back({2'd0, 1'b0, 32'd0});
      bq = {32'd7};
      send_beats(bq, 1);
      wait_idle();

      // 2: mode0, + 1 2 * 3 2, results 6 then 3
      issue(2'd0, 4'd6, 48'h23A218, 1'b0, 6, a);
      wait_burst_end(w);
      check("t2_burst_len", 32'(w), 32'(a + 6));
      done_q.push_back({2'd0, 1'b0, 32'd0});
      bq = {32'd6, 32'd3};
      send_beats(bq, 2);
      wait_idle();

      // 3: rejected lengths, done/err=1 on the cycle after accept, ready after the gap
      for (int r = 0; r < 5; r++) begin
         issue(REJ_MODE[r], REJ_LEN[r], 48'h123, 1'b1, 0, a);
         @(negedge clk); check("rej_busy0", 32'(bus.cmd_ready), 32'd0);
         @(negedge clk); check("rej_busy1", 32'(bus.cmd_ready), 32'd0);
         @(negedge clk); check("rej_ready_back", 32'(bus.cmd_ready), 32'd1);
      end
      wait_idle();

      // Boundary accepts: shortest stack expression and the full 12-token sorted one
      issue(2'd3, 4'd1, 48'h5, 1'b0, 1, a);
      wait_burst_end(w);
      check("len1_burst_len", 32'(w), 32'(a + 1));
      done_q.push_back({2'd0, 1'b0, 32'd0});
      bq = {32'hFFFF_FFFB};
      send_beats(bq, 1);
      wait_idle();

      issue(2'd1, 4'd12, 48'h123456789ABC, 1'b0, 12, a);
      wait_burst_end(w);
      check("len12_burst_len", 32'(w), 32'(a + 12));
      done_q.push_back({2'd0, 1'b0, 32'd0});
      bq = {32'd1, 32'd2, 32'd3, 32'd4};
      send_beats(bq, 4);
      wait_idle();

      // 4: silent evaluator, timeout exactly TMO cycles after WAIT entry
      issue(2'd2, 4'd3, 48'h219, 1'b0, 3, a);
      wait_burst_end(w);
      check("t4_burst_len", 32'(w), 32'(a + 3));
      done_q.push_back({2'd2, 1'b1, 32'(w + TMO)});
      wait_idle();

      // 5: one extra result beat -> forwarded without last, err=3
      issue(2'd1, 4'd6, 48'h8A1234, 1'b0, 6, a);
      wait_burst_end(w);
      done_q.push_back({2'd3, 1'b0, 32'd0});
      bq = {32'd10, 32'hFFFF_FFEC, 32'd30};
      send_beats(bq, 2);
      wait_idle();

      // 6: reset during a 9-token burst after the second token
      issue(2'd0, 4'd9, 48'h123456789, 1'b0, 2, a);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t6_in_valid_async", 32'(bus.in_valid), 32'd0);
      check("t6_cmd_ready_rst", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      check("t6_cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
      check("t6_no_done", 32'(bus.done), 32'd0);
      issue(2'd3, 4'd3, 48'h821, 1'b0, 3, a);
      wait_burst_end(w);
      check("t6_burst_len", 32'(w), 32'(a + 3));
      done_q.push_back({2'd0, 1'b0, 32'd0});
      bq = {32'hFFFF_FFFF};
      send_beats(bq, 1);
      wait_idle();

      repeat (5) @(negedge clk);
      check("end_tok_q_empty", 32'(tok_q.size()), 32'd0);
      check("end_rsp_q_empty", 32'(rsp_q.size()), 32'd0);
      check("end_done_q_empty", 32'(done_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded 20000 cycles, expected completion");
      $fatal(1);
   end

endmodule
